piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parameterised parallel-in/serial-out shifter. It accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled cycle, LSB- or MSB-first. It supports back-to-back words with no idle gap and a shift-enable input for rate control. It sits between register/CSR logic and a serial line driver or bit-rate tick generator.

Parameters:
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 0, serial bit order: 0 sends bit 0 first, 1 sends bit WIDTH-1 first.
- IDLE_LEVEL, 0, value driven on o_data whenever no word is being sent.

Ports:
- i_clk  in  1  sole clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_load  in  1  load request (valid).
- i_data  in  WIDTH  parallel word; sampled only on an accepted load.
- i_en  in  1  shift enable / bit tick; a bit advances only on an edge where i_en=1.
- o_ready  out  1  block can accept a load this cycle.
- o_data  out  1  serial bit.
- o_valid  out  1  o_data carries a payload bit.
- o_last  out  1  the current bit is the final bit of the word.
- o_busy  out  1  a word is in progress (same as o_valid).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Internal state:
  - FSM with states IDLE and SHIFT.
  - WIDTH-bit shift register shreg.
  - Bit counter cnt, $clog2(WIDTH) bits wide, range 0..WIDTH-1, never wraps past WIDTH-1.
- While i_rst=1:
  - state=IDLE, cnt=0, shreg=0.
  - o_ready=0, o_valid=0, o_busy=0, o_last=0, o_data=IDLE_LEVEL.
  - Reset asserted mid-word aborts the word immediately; no further bits are emitted.
- Accept condition: an edge where i_load=1 and o_ready=1.
  - On that edge: shreg<=i_data, cnt<=0, state<=SHIFT.
  - i_load while o_ready=0 is ignored; shreg is untouched and the request is not queued.
- Output decode (combinational from registered state):
  - o_valid = o_busy = (state==SHIFT).
  - o_data = shreg[0] if MSB_FIRST=0, else shreg[WIDTH-1]; o_data = IDLE_LEVEL in IDLE.
  - o_last = (state==SHIFT) && (cnt==WIDTH-1).
  - o_ready = !i_rst && (state==IDLE || (o_last && i_en)).
- Latency: bit 0 of the word order is on o_data in the cycle right after the accepting edge. It stays there until the first edge with i_en=1.
- SHIFT state, edge with i_en=1 and o_last=0:
  - shreg shifts toward the output end (right if MSB_FIRST=0, left otherwise), fill bit 0.
  - cnt<=cnt+1.
- SHIFT state, edge with i_en=0: everything holds, so bits stretch across any number of cycles.
- SHIFT state, edge with i_en=1 and o_last=1:
  - If i_load=1: reload per the accept condition and stay in SHIFT. The new word's first bit appears in the next cycle with no gap.
  - Otherwise: state<=IDLE.
- In IDLE, i_en has no effect.
- A word always takes exactly WIDTH enabled edges from the accept to completion.

Test Plan:
- Basic LSB-first: WIDTH=8, MSB_FIRST=0, i_en=1, load 0x1E. Required: o_data=0,1,1,1,1,0,0,0 on 8 consecutive cycles; o_valid high for exactly 8 cycles; o_last only on the 8th; then o_data=IDLE_LEVEL and o_ready=1.
- MSB-first: MSB_FIRST=1, load 0x1E. Required: o_data=0,0,0,1,1,1,1,0.
- Enable gating: i_en pulsed every 3rd cycle, load 0x81. Required: each bit held 3 cycles; o_busy spans 24 cycles; bit sequence unchanged (1,0,0,0,0,0,0,1).
- Back-to-back: hold i_load=1 with 0x0F then 0xF0, i_en=1. Required: 16 contiguous valid bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; o_ready=1 only in the last-bit cycle; o_valid never drops.
- Ignored load: during word 0x55, pulse i_load with 0xFF mid-word (o_ready=0). Required: the 0x55 bit stream is unaffected and no second word follows.
- Reset mid-word: assert i_rst after 3 bits of 0xAA. Required: outputs reach reset values asynchronously within the same cycle; after release, o_ready=1 and o_valid=0 until a new load.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master drives load/data/enable; the serializer (slave) drives the serial side.
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic             i_load;
   logic [WIDTH-1:0] i_data;
   logic             i_en;
   logic             o_ready;
   logic             o_data;
   logic             o_valid;
   logic             o_last;
   logic             o_busy;

   modport master (
      output i_load, i_data, i_en,
      input  o_ready, o_data, o_valid, o_last, o_busy
   );

   modport slave (
      input  i_load, i_data, i_en,
      output o_ready, o_data, o_valid, o_last, o_busy
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: one WIDTH-bit word per valid/ready load,
// one bit per enabled edge, back-to-back words with no idle gap.
module piso_serializer #(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   piso_serializer_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             ready;
   logic             accept;
   logic             out_bit;

   assign last    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
   // The final enabled edge of a word doubles as the accept slot for the next one.
   assign ready   = !i_rst && ((state == IDLE) || (last && bus.i_en));
   assign accept  = bus.i_load && ready;
   assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else if (accept) begin
         state <= SHIFT;
         cnt   <= '0;
         shreg <= bus.i_data;
      end else if (state == SHIFT && bus.i_en) begin
         if (last) begin
            state <= IDLE;
         end else begin
            cnt   <= cnt + 1'b1;
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
         end
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_valid = (state == SHIFT);
   assign bus.o_busy  = (state == SHIFT);
   assign bus.o_last  = last;
   assign bus.o_data  = (state == SHIFT) ? out_bit : IDLE_LEVEL;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an LSB-first and an MSB-first instance,
// expected bit streams queued at load time and popped as bits complete.
module tb_piso_serializer;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   typedef struct packed {logic d; logic l;} exp_t;
   exp_t q0[$];
   exp_t q1[$];

   piso_serializer_if #(.WIDTH(8)) b0 ();
   piso_serializer_if #(.WIDTH(8)) b1 ();

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (
      .i_clk(i_clk), .i_rst(i_rst), .bus(b0));
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u1 (
      .i_clk(i_clk), .i_rst(i_rst), .bus(b1));

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push0(input logic [7:0] w);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.d = w[i];
         e.l = (i == 7);
         q0.push_back(e);
      end
   endtask

   task automatic push1(input logic [7:0] w);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.d = w[7-i];
         e.l = (i == 7);
         q1.push_back(e);
      end
   endtask

   // Scoreboard: a held bit is checked every cycle, popped on its enabled edge.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (b0.o_valid) begin
            chk("lsb_bit_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
               chk("lsb_data", 32'(b0.o_data), 32'(q0[0].d));
               chk("lsb_last", 32'(b0.o_last), 32'(q0[0].l));
               chk("lsb_busy", 32'(b0.o_busy), 32'd1);
               if (b0.i_en) void'(q0.pop_front());
            end
         end
         if (b1.o_valid) begin
            chk("msb_bit_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
               chk("msb_data", 32'(b1.o_data), 32'(q1[0].d));
               chk("msb_last", 32'(b1.o_last), 32'(q1[0].l));
               if (b1.i_en) void'(q1.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lastpos;
      int rdy_cnt;
      int rdy_bad;
      b0.i_load = 1'b0; b0.i_data = '0; b0.i_en = 1'b0;
      b1.i_load = 1'b0; b1.i_data = '0; b1.i_en = 1'b0;

      // Reset values
      #2;
      chk("rst_ready", 32'(b0.o_ready), 32'd0);
      chk("rst_valid", 32'(b0.o_valid), 32'd0);
      chk("rst_busy",  32'(b0.o_busy),  32'd0);
      chk("rst_last",  32'(b0.o_last),  32'd0);
      chk("rst_data0", 32'(b0.o_data),  32'd0);
      chk("rst_data1", 32'(b1.o_data),  32'd1);
      cyc(); cyc();
      i_rst = 1'b0;
      b0.i_en = 1'b1; b1.i_en = 1'b1;
      #1;
      chk("idle_ready", 32'(b0.o_ready), 32'd1);
      chk("idle_valid", 32'(b0.o_valid), 32'd0);
      cyc();

      // Basic LSB-first 0x1E
      b0.i_load = 1'b1; b0.i_data = 8'h1E; push0(8'h1E);
      cyc();
      b0.i_load = 1'b0;
      n = 0; lastpos = -1;
      while (b0.o_valid && n < 50) begin
         if (b0.o_last) lastpos = n;
         n++;
         cyc();
      end
      chk("lsb_len", 32'(n), 32'd8);
      chk("lsb_lastpos", 32'(lastpos), 32'd7);
      chk("lsb_idle_data", 32'(b0.o_data), 32'd0);
      chk("lsb_idle_ready", 32'(b0.o_ready), 32'd1);

      // MSB-first 0x1E, idle level 1
      b1.i_load = 1'b1; b1.i_data = 8'h1E; push1(8'h1E);
      cyc();
      b1.i_load = 1'b0;
      n = 0;
      while (b1.o_valid && n < 50) begin
         n++;
         cyc();
      end
      chk("msb_len", 32'(n), 32'd8);
      chk("msb_idle_data", 32'(b1.o_data), 32'd1);
      chk("msb_idle_ready", 32'(b1.o_ready), 32'd1);

      // Enable gating: one enabled edge every 3rd cycle
      b0.i_load = 1'b1; b0.i_data = 8'h81; push0(8'h81);
      cyc();
      b0.i_load = 1'b0;
      n = 0;
      while (b0.o_busy && n < 100) begin
         b0.i_en = ((n % 3) == 2);
         n++;
         cyc();
      end
      b0.i_en = 1'b1;
      chk("gate_busy_len", 32'(n), 32'd24);
      chk("gate_q_empty", 32'(q0.size()), 32'd0);

      // Back-to-back 0x0F then 0xF0 with load held
      b0.i_load = 1'b1; b0.i_data = 8'h0F; push0(8'h0F);
      cyc();
      b0.i_data = 8'hF0; push0(8'hF0);
      n = 0; rdy_cnt = 0; rdy_bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) b0.i_load = 1'b0;
         if (b0.o_valid) n++;
         if (b0.o_ready) rdy_cnt++;
         if (b0.o_ready !== b0.o_last) rdy_bad++;
         cyc();
      end
      chk("b2b_valid_cnt", 32'(n), 32'd16);
      chk("b2b_ready_cnt", 32'(rdy_cnt), 32'd2);
      chk("b2b_ready_only_last", 32'(rdy_bad), 32'd0);
      chk("b2b_end_valid", 32'(b0.o_valid), 32'd0);

      // Load ignored mid-word
      b0.i_load = 1'b1; b0.i_data = 8'h55; push0(8'h55);
      cyc();
      b0.i_load = 1'b0;
      cyc(); cyc();
      chk("ign_ready_low", 32'(b0.o_ready), 32'd0);
      b0.i_load = 1'b1; b0.i_data = 8'hFF;
      cyc();
      b0.i_load = 1'b0;
      n = 0;
      while (b0.o_valid && n < 50) begin
         n++;
         cyc();
      end
      chk("ign_rest_len", 32'(n), 32'd5);
      cyc(); cyc();
      chk("ign_no_second", 32'(b0.o_valid), 32'd0);
      chk("ign_q_empty", 32'(q0.size()), 32'd0);

      // Reset mid-word after 3 bits of 0xAA
      b0.i_load = 1'b1; b0.i_data = 8'hAA; push0(8'hAA);
      cyc();
      b0.i_load = 1'b0;
      cyc(); cyc(); cyc();
      chk("rmw_q_left", 32'(q0.size()), 32'd5);
      #2 i_rst = 1'b1;
      #1;
      chk("rmw_valid", 32'(b0.o_valid), 32'd0);
      chk("rmw_ready", 32'(b0.o_ready), 32'd0);
      chk("rmw_last",  32'(b0.o_last),  32'd0);
      chk("rmw_data",  32'(b0.o_data),  32'd0);
      q0.delete();
      cyc();
      i_rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_ready", 32'(b0.o_ready), 32'd1);
         chk("post_rst_valid", 32'(b0.o_valid), 32'd0);
         cyc();
      end
      chk("final_q1_empty", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
